// File: rtl/reg16_write_sequencer_if.sv
// Write-side bus of the 16-bit adiabatic register: valid/ready word handshake,
// register data bus, four power-clock phase pins, readback, done and err.
interface reg16_write_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic [WIDTH-1:0] reg_in;
    logic             Fclkpos;
    logic             Fclkneg;
    logic             clkpos;
    logic             clkneg;
    logic [WIDTH-1:0] reg_q;
    logic             done;
    logic             err;

    // The sequencer is the slave; the datapath/test side is the master.
    modport slave (
        input  wr_valid, wr_data, reg_q,
        output wr_ready, reg_in, Fclkpos, Fclkneg, clkpos, clkneg, done, err
    );

    modport master (
        output wr_valid, wr_data, reg_q,
        input  wr_ready, reg_in, Fclkpos, Fclkneg, clkpos, clkneg, done, err
    );
endinterface

// File: rtl/reg16_write_sequencer.sv
// Writer for the 16-bit adiabatic register: latches one word per handshake and
// steps the Fclk/clk power-clock phases. Optional macro READBACK_CHECK_EN adds a readback compare.
module reg16_write_sequencer #(
    parameter int WIDTH       = 16,
    parameter int RAMP_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg16_write_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (RAMP_CYCLES > HOLD_CYCLES) ? RAMP_CYCLES : HOLD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] RAMP_LOAD = CW'(RAMP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic [2:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] reg_in_q;
    logic             ready_q;
    logic             fclkpos_q, fclkneg_q;
    logic             clkpos_q, clkneg_q;
    logic             done_q;
    logic             err_q, err_d;
    logic             handshake;
    logic             finishing;

    assign handshake = (state == S_IDLE) && bus.wr_valid;

    // Each busy state counts down from its load value and moves on at zero.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        finishing = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_d = S_SETUP;
                    cnt_d   = RAMP_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt == CNT_ZERO) begin
                    state_d = S_CAPTURE;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_CAPTURE: begin
                if (cnt == CNT_ZERO) begin
                    state_d = S_RELEASE;
                    cnt_d   = RAMP_LOAD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (cnt == CNT_ZERO) begin
                    state_d = S_RECOVER;
                    cnt_d   = RAMP_LOAD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_RECOVER: begin
                if (cnt == CNT_ZERO) begin
                    state_d   = S_IDLE;
                    cnt_d     = CNT_ZERO;
                    finishing = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

`ifdef READBACK_CHECK_EN
    // The register has settled by the last RECOVER cycle; a mismatch there is latched until the next word.
    always_comb begin
        err_d = err_q;
        if (handshake) begin
            err_d = 1'b0;
        end else if (finishing && (bus.reg_q != reg_in_q)) begin
            err_d = 1'b1;
        end
    end
`else
    logic unused_reg_q;
    assign unused_reg_q = ^bus.reg_q;

    always_comb begin
        err_d = 1'b0;
    end
`endif

    // Phase pins are decoded from the next state, so they only move on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= CNT_ZERO;
            reg_in_q  <= '0;
            ready_q   <= 1'b1;
            fclkpos_q <= 1'b0;
            fclkneg_q <= 1'b1;
            clkpos_q  <= 1'b0;
            clkneg_q  <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ready_q   <= (state_d == S_IDLE);
            fclkpos_q <= (state_d == S_SETUP) || (state_d == S_CAPTURE) || (state_d == S_RELEASE);
            fclkneg_q <= !((state_d == S_SETUP) || (state_d == S_CAPTURE) || (state_d == S_RELEASE));
            clkpos_q  <= (state_d == S_CAPTURE);
            clkneg_q  <= (state_d != S_CAPTURE);
            done_q    <= finishing;
            err_q     <= err_d;
            if (handshake) begin
                reg_in_q <= bus.wr_data;
            end
        end
    end

    assign bus.wr_ready = ready_q;
    assign bus.reg_in   = reg_in_q;
    assign bus.Fclkpos  = fclkpos_q;
    assign bus.Fclkneg  = fclkneg_q;
    assign bus.clkpos   = clkpos_q;
    assign bus.clkneg   = clkneg_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_reg16_write_sequencer.sv
// Self-checking bench for reg16_write_sequencer: a cycle-offset timing model plus a
// scoreboard of accepted words checked against each done pulse.
module tb_reg16_write_sequencer;

    localparam int RAMP     = 2;
    localparam int HOLD     = 1;
    localparam int LAT      = 3 * RAMP + HOLD;
    localparam int DONE_POS = LAT + 1;

    typedef struct {
        logic [15:0] data;
        int          acceptCyc;
    } item_t;

    logic clk;
    logic rst_n;
    logic forceZero;
    logic checking;

    int nChecks;
    int nFails;
    int pos;
    int cyc;
    int acceptCount;
    logic [15:0] lastData;
    logic        errModel;
    item_t       sb[$];

    reg16_write_sequencer_if #(.WIDTH(16)) bus ();

    reg16_write_sequencer #(
        .WIDTH(16),
        .RAMP_CYCLES(RAMP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // The storage element reads back what it was given unless the bench forces a stuck-at-zero register.
    assign bus.reg_q = forceZero ? 16'h0000 : bus.reg_in;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Timing model: pos counts cycles since the accepting edge; 0 or DONE_POS means idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= 0;
            lastData <= '0;
            errModel <= 1'b0;
            sb.delete();
        end else begin
            cyc <= cyc + 1;
            if (((pos == 0) || (pos == DONE_POS)) && bus.wr_valid) begin
                pos         <= 1;
                lastData    <= bus.wr_data;
                errModel    <= 1'b0;
                acceptCount <= acceptCount + 1;
                sb.push_back('{bus.wr_data, cyc + 1});
            end else if ((pos > 0) && (pos < DONE_POS)) begin
                pos <= pos + 1;
`ifdef READBACK_CHECK_EN
                if ((pos == LAT) && forceZero && (lastData != 16'h0000)) begin
                    errModel <= 1'b1;
                end
`endif
            end else begin
                pos <= 0;
            end
        end
    end

    // Every cycle, compare the phase pins, bus and flags with the model; pop the scoreboard on done.
    always @(negedge clk) begin : monitor
        item_t it;
        logic  expF;
        logic  expC;
        if (checking) begin
            expF = (pos >= 1) && (pos <= 2 * RAMP + HOLD);
            expC = (pos >= RAMP + 1) && (pos <= RAMP + HOLD);
            checkOutput("Fclkpos", 32'(bus.Fclkpos), 32'(expF));
            checkOutput("Fclkneg", 32'(bus.Fclkneg), 32'(!expF));
            checkOutput("clkpos", 32'(bus.clkpos), 32'(expC));
            checkOutput("clkneg", 32'(bus.clkneg), 32'(!expC));
            checkOutput("wr_ready", 32'(bus.wr_ready), 32'((pos == 0) || (pos == DONE_POS)));
            checkOutput("done", 32'(bus.done), 32'(pos == DONE_POS));
            checkOutput("reg_in", 32'(bus.reg_in), 32'(lastData));
            checkOutput("err", 32'(bus.err), 32'(errModel));
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    it = sb.pop_front();
                    checkOutput("sb_data", 32'(bus.reg_in), 32'(it.data));
                    checkOutput("sb_latency", 32'(cyc - it.acceptCyc), 32'(LAT));
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] data);
        @(negedge clk);
        #1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic waitAccept(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (acceptCount >= target) seen = 1'b1;
        end
        if (!seen) checkOutput("accept_timeout", 32'(acceptCount), 32'(target));
    endtask

    task automatic waitPos(input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pos == p) seen = 1'b1;
        end
        if (!seen) checkOutput("pos_timeout", 32'(pos), 32'(p));
    endtask

    task automatic checkRest(input string tag);
        checkOutput({tag, "_Fclkpos"}, 32'(bus.Fclkpos), 32'd0);
        checkOutput({tag, "_Fclkneg"}, 32'(bus.Fclkneg), 32'd1);
        checkOutput({tag, "_clkpos"}, 32'(bus.clkpos), 32'd0);
        checkOutput({tag, "_clkneg"}, 32'(bus.clkneg), 32'd1);
        checkOutput({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_reg_in"}, 32'(bus.reg_in), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCount;
        nChecks      = 0;
        nFails       = 0;
        cyc          = 0;
        acceptCount  = 0;
        checking     = 1'b0;
        forceZero    = 1'b0;
        rst_n        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;

        #1 rst_n = 1'b0;
        #1;
        checking = 1'b1;
        checkRest("reset");
        idleCycles(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] single write A5C3");
        applyStimulus(16'hA5C3);
        idleCycles(10);

        $display("[TB] back-to-back 0001 / FFFF");
        startCount = acceptCount;
        @(negedge clk);
        #1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h0001;
        waitAccept(startCount + 1);
        bus.wr_data  = 16'hFFFF;
        waitAccept(startCount + 2);
        bus.wr_valid = 1'b0;
        idleCycles(10);

        $display("[TB] wr_valid pulsed during CAPTURE");
        applyStimulus(16'h1357);
        waitPos(RAMP + 1);
        #1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hBEEF;
        @(posedge clk);
        #1 bus.wr_valid = 1'b0;
        idleCycles(10);

        $display("[TB] reset during CAPTURE");
        applyStimulus(16'h2468);
        waitPos(RAMP + 1);
        #1 rst_n = 1'b0;
        #1;
        checkRest("midreset");
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idleCycles(5);

        $display("[TB] random words");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'($urandom));
            idleCycles(9);
        end

        $display("[TB] readback with stuck register");
        forceZero = 1'b1;
        applyStimulus(16'h1234);
        idleCycles(12);
        forceZero = 1'b0;
        idleCycles(3);
        applyStimulus(16'h5555);
        idleCycles(10);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
